// File: rtl/dcs_gram_attn.sv
// dcs_gram_attn: streams a ROWS x COLS matrix, accumulates its Gram matrix, optionally
// zeroes entries below the row mean, then multiplies by a streamed weight vector.
module dcs_gram_attn #(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int DW   = 8,
    parameter int OW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          thr_en,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [OW-1:0] o_data
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int HW = 2*DW + $clog2(COLS);
    localparam int SW = HW + RW;
    localparam int AW = HW + DW + RW;

    typedef enum logic [1:0] {LOAD, THRESH, WEIGHT, OUT} state_t;

    state_t        state;
    logic          thr;
    logic [RW-1:0] r, wc, k;
    logic [CW-1:0] c;
    logic [DW-1:0] x     [ROWS][COLS];
    logic [HW-1:0] h     [ROWS][ROWS];
    logic [AW-1:0] acc   [ROWS];
    logic [2*DW-1:0] p   [ROWS];
    logic [SW-1:0] avg   [ROWS];
    logic [AW-1:0] acc_n [ROWS];

    // p[j] is X[r][c]*X[j][c] for j<r and X[r][c]^2 on the diagonal
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            p[i] = (2*DW)'(i_data) * (2*DW)'((RW'(i) == r) ? i_data : x[i][c]);
            avg[i] = '0;
            for (int j = 0; j < ROWS; j++) avg[i] = avg[i] + SW'(h[i][j]);
            avg[i] = avg[i] >> RW;
            acc_n[i] = acc[i] + AW'(h[i][wc]) * AW'(w_data);
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && i_valid) x[r][c] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            i_ready <= 1'b1;
            w_ready <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            thr     <= 1'b0;
            r       <= '0;
            c       <= '0;
            wc      <= '0;
            k       <= '0;
            for (int i = 0; i < ROWS; i++) begin
                acc[i] <= '0;
                for (int j = 0; j < ROWS; j++) h[i][j] <= '0;
            end
        end else begin
            case (state)
                LOAD: if (i_valid) begin
                    if (r == '0 && c == '0) thr <= thr_en;
                    for (int i = 0; i < ROWS; i++)
                        for (int j = 0; j < ROWS; j++)
                            if (RW'(i) == r && RW'(j) <= r) h[i][j] <= h[i][j] + HW'(p[j]);
                            else if (RW'(j) == r && RW'(i) < r) h[i][j] <= h[i][j] + HW'(p[i]);
                    c <= (c == CW'(COLS-1)) ? '0 : c + 1'b1;
                    if (c == CW'(COLS-1)) begin
                        r <= r + 1'b1;
                        if (r == RW'(ROWS-1)) begin
                            state   <= THRESH;
                            i_ready <= 1'b0;
                        end
                    end
                end
                THRESH: begin
                    for (int i = 0; i < ROWS; i++)
                        for (int j = 0; j < ROWS; j++)
                            if (thr && SW'(h[i][j]) < avg[i]) h[i][j] <= '0;
                    state   <= WEIGHT;
                    w_ready <= 1'b1;
                end
                WEIGHT: if (w_valid) begin
                    for (int i = 0; i < ROWS; i++) acc[i] <= acc_n[i];
                    wc <= wc + 1'b1;
                    if (wc == RW'(ROWS-1)) begin
                        state   <= OUT;
                        w_ready <= 1'b0;
                        o_valid <= 1'b1;
                        o_data  <= OW'(acc_n[0]);
                    end
                end
                OUT: if (o_ready) begin
                    if (k == RW'(ROWS-1)) begin
                        k       <= '0;
                        o_valid <= 1'b0;
                        o_data  <= '0;
                        i_ready <= 1'b1;
                        state   <= LOAD;
                        for (int i = 0; i < ROWS; i++) begin
                            acc[i] <= '0;
                            for (int j = 0; j < ROWS; j++) h[i][j] <= '0;
                        end
                    end else begin
                        k      <= k + 1'b1;
                        o_data <= OW'(acc[k + 1'b1]);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcs_gram_attn.sv
// tb_dcs_gram_attn: table-driven and randomized frames for dcs_gram_attn against a
// matrix-level reference model, plus reset, latency and backpressure sequences.
module tb_dcs_gram_attn;
    localparam int ROWS = 8, COLS = 16, DW = 8, OW = 32, LIM = 200;

    logic clk = 0, rst_n = 0, thr_en = 0, i_valid = 0, w_valid = 0, o_ready = 0;
    logic [DW-1:0] i_data = '0, w_data = '0;
    logic i_ready, w_ready, o_valid;
    logic [OW-1:0] o_data;

    int checks = 0, errors = 0, gap = 0;
    int fx [ROWS][COLS];
    int fw [ROWS];
    logic [OW-1:0] got [ROWS];
    longint exp_o [ROWS];

    typedef struct {
        int     xk;
        int     xv;
        bit     thr;
        int     wv;
        longint e;
        bit     lin;
    } vec_t;
    vec_t vecs [5];

    dcs_gram_attn #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .thr_en(thr_en),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input bit thr);
        longint h [ROWS][ROWS];
        longint s;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < ROWS; j++) begin
                h[i][j] = 0;
                for (int c = 0; c < COLS; c++) h[i][j] += longint'(fx[i][c]) * fx[j][c];
            end
        for (int i = 0; i < ROWS; i++) begin
            s = 0;
            for (int j = 0; j < ROWS; j++) s += h[i][j];
            s = s / ROWS;
            if (thr) for (int j = 0; j < ROWS; j++) if (h[i][j] < s) h[i][j] = 0;
        end
        for (int i = 0; i < ROWS; i++) begin
            s = 0;
            for (int j = 0; j < ROWS; j++) s += h[i][j] * fw[j];
            exp_o[i] = s & ((64'sd1 <<< OW) - 1);
        end
    endfunction

    task automatic put_x(input int d);
        int n = 0;
        while ($urandom_range(0, 99) < gap) begin
            i_valid = 0; i_data = DW'($urandom); @(negedge clk);
        end
        i_valid = 1; i_data = DW'(d);
        while (!i_ready && n < LIM) begin @(negedge clk); n++; end
        chk("i_ready wait", i_ready, 1);
        @(negedge clk);
        i_valid = 0;
    endtask

    task automatic put_w(input int d);
        int n = 0;
        while ($urandom_range(0, 99) < gap) begin
            w_valid = 0; w_data = DW'($urandom); @(negedge clk);
        end
        w_valid = 1; w_data = DW'(d);
        while (!w_ready && n < LIM) begin @(negedge clk); n++; end
        chk("w_ready wait", w_ready, 1);
        @(negedge clk);
        w_valid = 0;
    endtask

    task automatic load_x(input bit thr);
        thr_en = thr;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                w_valid = 1; w_data = DW'($urandom);
                put_x(fx[r][c]);
                thr_en = 1'($urandom);
            end
        w_valid = 0;
        chk("thresh i_ready", i_ready, 0);
        chk("thresh w_ready", w_ready, 0);
        @(negedge clk);
        chk("w_ready at t+2", w_ready, 1);
    endtask

    task automatic send_w(input int cnt);
        for (int j = 0; j < cnt; j++) begin
            if (j == ROWS - 1) chk("o_valid before last w", o_valid, 0);
            i_valid = 1; i_data = DW'($urandom);
            put_w(fw[j]);
        end
        i_valid = 0;
        if (cnt == ROWS) chk("o_valid at u+1", o_valid, 1);
    endtask

    task automatic collect(input int stall_at);
        for (int i = 0; i < ROWS; i++) begin
            int n = 0;
            if (i == stall_at) begin
                logic [OW-1:0] held;
                o_ready = 0; held = o_data;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall o_valid", o_valid, 1);
                    chk("stall o_data", o_data, held);
                end
            end
            o_ready = $urandom_range(0, 99) >= gap;
            while (!(o_valid && o_ready) && n < LIM) begin
                @(negedge clk); n++; o_ready = $urandom_range(0, 99) >= gap;
            end
            chk("o handshake wait", 64'(n < LIM), 1);
            got[i] = o_data;
            @(negedge clk);
        end
        o_ready = 0;
        chk("i_ready at v+1", i_ready, 1);
        chk("o_valid at v+1", o_valid, 0);
    endtask

    task automatic run_frame(input bit thr, input int stall_at);
        load_x(thr);
        send_w(ROWS);
        collect(stall_at);
        for (int i = 0; i < ROWS; i++) chk($sformatf("out[%0d]", i), got[i], exp_o[i]);
    endtask

    task automatic rand_fill(input int maxv);
        for (int r = 0; r < ROWS; r++) begin
            fw[r] = $urandom_range(0, 255);
            for (int c = 0; c < COLS; c++) fx[r][c] = $urandom_range(0, maxv);
        end
    endtask

    initial begin
        vecs[0] = '{0, 1,   1'b1, 1,   128,        1'b0};
        vecs[1] = '{1, 0,   1'b1, 1,   416,        1'b1};
        vecs[2] = '{1, 0,   1'b0, 1,   576,        1'b1};
        vecs[3] = '{0, 255, 1'b0, 255, 2122416000, 1'b0};
        vecs[4] = '{0, 2,   1'b1, 3,   1536,       1'b0};

        repeat (3) @(negedge clk);
        chk("reset i_ready", i_ready, 1);
        chk("reset w_ready", w_ready, 0);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_data", o_data, 0);
        rst_n = 1;
        @(negedge clk);

        foreach (vecs[v]) begin
            for (int r = 0; r < ROWS; r++) begin
                fw[r] = vecs[v].wv;
                for (int c = 0; c < COLS; c++) fx[r][c] = vecs[v].xk ? r + 1 : vecs[v].xv;
            end
            for (int i = 0; i < ROWS; i++) exp_o[i] = vecs[v].lin ? vecs[v].e * (i + 1) : vecs[v].e;
            run_frame(vecs[v].thr, v == 1 ? 2 : -1);
        end

        rand_fill(255);
        load_x(1);
        send_w(3);
        rst_n = 0;
        #1;
        chk("midreset i_ready", i_ready, 1);
        chk("midreset w_ready", w_ready, 0);
        chk("midreset o_valid", o_valid, 0);
        chk("midreset o_data", o_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        rand_fill(255);
        model(1);
        run_frame(1, -1);

        for (int f = 0; f < 8; f++) begin
            gap = $urandom_range(0, 60);
            rand_fill(f % 2 ? 255 : 7);
            model(f[0] ^ f[1]);
            run_frame(f[0] ^ f[1], f == 3 ? 5 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
